// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
// Optional macro CLKDIV_SYNC_EN enables the SYNC phase-align restart.
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 24,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] EN,
    input  logic              DIV_WE,
    input  logic [2:0]        DIV_SEL,
    input  logic [CNT_W-1:0]  DIV_DATA,
    input  logic              SYNC,
    output logic [NUM_CH-1:0] CLKOUT,
    output logic [NUM_CH-1:0] TICK,
    output logic [NUM_CH-1:0] PEND
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = SYNC;
`else
    logic unused_sync;
    assign unused_sync = SYNC;
    assign sync_hit    = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] pen_div;
        logic             clk_q;
        logic             tick_q;
        logic             pend_q;
        logic             wr;
        logic             tc;
        logic             apply;

        assign wr = DIV_WE && (DIV_SEL == 3'(g));
        assign tc = (cnt == act_div);
        // Pending divisor lands only on a half-period boundary, so no toggle is ever cut short.
        assign apply = pend_q && (!EN[g] || sync_hit || tc);

        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt     <= '0;
                act_div <= RST_DIV;
                pen_div <= RST_DIV;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                if (wr)
                    pen_div <= DIV_DATA;
                if (apply)
                    act_div <= pen_div;
                // A write coinciding with an apply stays pending for the next boundary.
                if (wr)
                    pend_q <= 1'b1;
                else if (apply)
                    pend_q <= 1'b0;

                if (!EN[g] || sync_hit) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (tc) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= 1'b1;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end
            end
        end

        assign CLKOUT[g] = clk_q;
        assign TICK[g]   = tick_q;
        assign PEND[g]   = pend_q;
    end

endmodule
